// File: rtl/seq_patdet_pkg.sv
// seq_patdet_pkg: shared sizes and match-mode encoding for the serial pattern detector.
package seq_patdet_pkg;
    localparam int MAX_PAT_LEN = 32;
    localparam int DEF_PAT_LEN = 3;
    localparam int DEF_CNT_W   = 8;
    typedef enum logic {PD_OVERLAP, PD_NONOVERLAP} pd_mode_e;
endpackage

// File: rtl/seq_patdet_if.sv
// seq_patdet_if: serial stream, configuration and match status bundle of the pattern detector.
interface seq_patdet_if
    import seq_patdet_pkg::*;
#(
    parameter int PAT_LEN = DEF_PAT_LEN,
    parameter int CNT_W   = DEF_CNT_W
);
    logic               in_valid;
    logic               in;
    logic               cfg_we;
    logic [PAT_LEN-1:0] cfg_pattern;
    logic [PAT_LEN-1:0] cfg_mask;
    logic               overlap_en;
    logic               cnt_clr;
    logic               z;
    logic [CNT_W-1:0]   match_cnt;
    modport master (
        output in_valid, in, cfg_we, cfg_pattern, cfg_mask, overlap_en, cnt_clr,
        input  z, match_cnt
    );
    modport slave (
        input  in_valid, in, cfg_we, cfg_pattern, cfg_mask, overlap_en, cnt_clr,
        output z, match_cnt
    );
endinterface

// File: rtl/patdet_sat_counter.sv
// patdet_sat_counter: saturating event counter; clear wins over a simultaneous increment.
module patdet_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr ? '0 : (inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
    assign cnt = cnt_q;
endmodule

// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector: programmable PAT_LEN-bit serial pattern detector with match pulse and counter.
// Define SEQ_PATDET_MASK_EN to add a per-bit compare mask loaded with cfg_we.
module seq_pattern_detector
    import seq_patdet_pkg::*;
#(
    parameter int                 PAT_LEN     = DEF_PAT_LEN,
    parameter int                 CNT_W       = DEF_CNT_W,
    parameter logic [PAT_LEN-1:0] RST_PATTERN = PAT_LEN'(3'b101)
) (
    input logic         clk,
    input logic         rst_n,
    seq_patdet_if.slave bus
);
    localparam int             FW   = $clog2(PAT_LEN + 1);
    localparam logic [FW-1:0]  FULL = FW'(PAT_LEN);
    logic [PAT_LEN-1:0] window_q, window_d, pattern_q, pattern_d, hit_mask;
    logic [FW-1:0]      fill_q, fill_d, fill_inc;
    logic               z_q, z_d, match;
    pd_mode_e           mode;
`ifdef SEQ_PATDET_MASK_EN
    logic [PAT_LEN-1:0] mask_q, mask_d;
    always_comb mask_d = bus.cfg_we ? bus.cfg_mask : mask_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mask_q <= '1;
        else        mask_q <= mask_d;
    end
    assign hit_mask = mask_q;
`else
    logic unused_mask;
    assign unused_mask = ^bus.cfg_mask;
    assign hit_mask    = '1;
`endif
    // fill gates matching so reset/config zeros in the window never count as pattern bits
    always_comb begin
        mode      = bus.overlap_en ? PD_OVERLAP : PD_NONOVERLAP;
        window_d  = window_q;
        pattern_d = pattern_q;
        fill_d    = fill_q;
        match     = 1'b0;
        fill_inc  = (fill_q == FULL) ? FULL : fill_q + 1'b1;
        if (bus.cfg_we) begin
            pattern_d = bus.cfg_pattern;
            window_d  = '0;
            fill_d    = '0;
        end else if (bus.in_valid) begin
            window_d = {window_q[PAT_LEN-2:0], bus.in};
            match    = (fill_inc == FULL) && (((window_d ^ pattern_q) & hit_mask) == '0);
            fill_d   = (match && mode == PD_NONOVERLAP) ? '0 : fill_inc;
        end
        z_d = match;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window_q  <= '0;
            pattern_q <= RST_PATTERN;
            fill_q    <= '0;
            z_q       <= 1'b0;
        end else begin
            window_q  <= window_d;
            pattern_q <= pattern_d;
            fill_q    <= fill_d;
            z_q       <= z_d;
        end
    end
    patdet_sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (match),
        .clr   (bus.cnt_clr),
        .cnt   (bus.match_cnt)
    );
    assign bus.z = z_q;
endmodule

// File: doc/seq_pattern_detector.md
Name: seq_pattern_detector

Overview:
- Parametrised successor to the fixed 3-bit serial pattern detector.
- Detects a programmable PAT_LEN-bit pattern on a qualified serial bit stream.
- Supports overlapping and non-overlapping match modes, a registered one-cycle match pulse, and a saturating match counter.
- Sits at the serial front end, between the bit recoveriser logic and the control/status registers.

Parameters:
- PAT_LEN, 3, pattern length in bits (2..32).
- CNT_W, 8, width of the match counter.
- RST_PATTERN, 3'b101, pattern loaded at reset (width PAT_LEN).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- in_valid  in  1  qualifies `in`; a bit is accepted only on cycles where in_valid=1.
- in  in  1  serial data bit.
- cfg_we  in  1  load cfg_pattern (and cfg_mask) and clear the detection history.
- cfg_pattern  in  PAT_LEN  new pattern; MSB is the first bit received.
- cfg_mask  in  PAT_LEN  per-bit compare enable; used only with the optional feature.
- overlap_en  in  1  1 = overlapping matches allowed; 0 = non-overlapping.
- cnt_clr  in  1  synchronous clear of match_cnt.
- z  out  1  one-cycle match pulse.
- match_cnt  out  CNT_W  number of matches, saturating.

Behaviour:
- Reset (async, rst_n=0):
  - window=0, fill=0, pattern=RST_PATTERN, mask=all-ones, z=0, match_cnt=0.
- Window:
  - PAT_LEN-bit shift register; newest bit in bit 0.
  - On each accepted bit: window_next = {window[PAT_LEN-2:0], in}.
- Fill counter:
  - Counts accepted bits since the last reset, cfg_we or non-overlap match; saturates at PAT_LEN.
  - No match is possible until fill_next reaches PAT_LEN, so zeros left over from reset never produce a false match.
- Match condition, evaluated on each accepted bit:
  - fill_next==PAT_LEN and window_next==pattern (masked compare when the optional feature is enabled).
- Latency:
  - z goes high for exactly one cycle, in the cycle after the edge that accepts the completing bit.
  - z stays 0 whenever in_valid=0.
- Overlap modes:
  - overlap_en=1: fill holds at PAT_LEN after a match; the next accepted bit can complete another match.
  - overlap_en=0: on a match, fill resets to 0, so the next match needs PAT_LEN fresh bits.
  - overlap_en is sampled each cycle; changing it mid-stream takes effect on the next accepted bit.
- Configuration:
  - cfg_we=1 loads pattern/mask and clears window and fill to 0.
  - If cfg_we and in_valid are high together, cfg_we wins: the bit is discarded and z=0 next cycle.
- Counter:
  - match_cnt increments on each match and saturates at 2^CNT_W-1; it does not wrap.
  - cnt_clr has priority: if a clear and a match occur in the same cycle, the result is 0.
  - cfg_we does not clear the counter.
- Reset mid-stream:
  - All state, including a pending z, is cleared immediately.
  - Detection restarts with fill=0.

Optional Feature:
- Macro: SEQ_PATDET_MASK_EN.
- Defined: cfg_mask is loaded with cfg_we.
  - Match is ((window_next ^ pattern) & mask)==0.
  - A mask of all zeros matches any PAT_LEN-bit window once fill is satisfied.
- Undefined: cfg_mask is ignored, no mask register is built, and the compare is exact equality.

Decomposition:
- Package seq_patdet_pkg holds:
  - MAX_PAT_LEN=32, DEF_PAT_LEN=3, DEF_CNT_W=8;
  - typedef enum of the mode {PD_OVERLAP, PD_NONOVERLAP} used by the bench and status decode.
- One sub-module is natural: patdet_sat_counter (CNT_W-wide, with inc, clr and clr-priority), reused by the other status counters.
- Window, fill and compare stay in the top module.

Test Plan:
- PAT_LEN=3, pattern 101, overlap_en=1, stream 1,0,1,0,1 (in_valid=1) -> z pulses after the 3rd and 5th bits; match_cnt=2.
- Same stream with overlap_en=0 -> z pulses after the 3rd bit only; match_cnt=1. Then feed 1,0,1 -> a second pulse; match_cnt=2.
- Stream 1,0 with in_valid dropped for 4 cycles, then 1 -> z=0 during the gap; one pulse after the final accepted 1.
- cfg_we loading pattern 110 after bits 1,1, with in_valid high in the same cycle -> that bit is discarded. Then 1,0 -> no match. Then 1,1,0 -> one pulse.
- CNT_W=2, 5 overlapping matches -> match_cnt 1,2,3,3,3. cnt_clr together with a match -> match_cnt=0.
- rst_n pulsed low mid-pattern after bits 1,0 -> z=0 and match_cnt=0 immediately. A following 1 alone does not match; a full 1,0,1 does.
- With SEQ_PATDET_MASK_EN defined: pattern 101, mask 101, stream 1,1,1 -> match. Without the macro, the same stream -> no match.
